// File: rtl/q_ao_unit_if.sv
// Signal bundle for the q_ao_unit AO21 self-check cell: a/b/c operands in,
// three variant results, the cross-check flag and per-variant rising-edge counters out.
interface q_ao_unit_if #(
    parameter int CNT_W = 16
);
    logic             a;
    logic             b;
    logic             c;
    logic             w1;
    logic             w3;
    logic             w5;
    logic             mismatch;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt3;
    logic [CNT_W-1:0] cnt5;

    modport master (
        output a, b, c,
        input  w1, w3, w5, mismatch, cnt1, cnt3, cnt5
    );

    modport slave (
        input  a, b, c,
        output w1, w3, w5, mismatch, cnt1, cnt3, cnt5
    );
endinterface

// File: rtl/q_ao_unit.sv
// Two-stage AO21 unit, w = (a & b) | c, built as three independent netlists and cross-checked.
// Optional per-variant saturating rising-edge counters are built when Q_AO_EDGE_COUNT_EN is defined.
module q_ao_unit (
    input  logic         clk,
    input  logic         rst,
    q_ao_unit_if.slave   bus
);
    logic a_q;
    logic b_q;
    logic c_q;

    // NOTE: every register uses <= so all flops sample pre-edge values and no ordering races exist.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 1'b0;
            b_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            a_q <= bus.a;
            b_q <= bus.b;
            c_q <= bus.c;
        end
    end

    // Variant 1: discrete AND2 into OR2.
    (* keep = "true" *) wire v1_and;
    (* keep = "true" *) wire v1;
    and u_v1_and (v1_and, a_q, b_q);
    or  u_v1_or  (v1, v1_and, c_q);

    // Variant 3: NAND2-NAND2 form with the OR input inverted.
    (* keep = "true" *) wire v3_nab;
    (* keep = "true" *) wire v3_nc;
    (* keep = "true" *) wire v3;
    nand u_v3_nab (v3_nab, a_q, b_q);
    not  u_v3_nc  (v3_nc, c_q);
    nand u_v3_out (v3, v3_nab, v3_nc);

    // Variant 5: AOI21 complex gate followed by an output inverter.
    (* keep = "true" *) wire v5_aoi;
    (* keep = "true" *) wire v5;
    assign v5_aoi = ~((a_q & b_q) | c_q);
    not u_v5_inv (v5, v5_aoi);

    logic mismatch_d;
    assign mismatch_d = (v1 ^ v3) | (v1 ^ v5);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.w1       <= 1'b0;
            bus.w3       <= 1'b0;
            bus.w5       <= 1'b0;
            bus.mismatch <= 1'b0;
        end else begin
            bus.w1       <= v1;
            bus.w3       <= v3;
            bus.w5       <= v5;
            bus.mismatch <= mismatch_d;
        end
    end

`ifdef Q_AO_EDGE_COUNT_EN
    // A rise is seen when the registered output is 0 and its next value is 1;
    // reset clears the counters directly, so the forced 1->0 never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cnt1 <= '0;
            bus.cnt3 <= '0;
            bus.cnt5 <= '0;
        end else begin
            if (!bus.w1 && v1 && (bus.cnt1 != '1)) bus.cnt1 <= bus.cnt1 + 1'b1;
            if (!bus.w3 && v3 && (bus.cnt3 != '1)) bus.cnt3 <= bus.cnt3 + 1'b1;
            if (!bus.w5 && v5 && (bus.cnt5 != '1)) bus.cnt5 <= bus.cnt5 + 1'b1;
        end
    end
`else
    assign bus.cnt1 = '0;
    assign bus.cnt3 = '0;
    assign bus.cnt5 = '0;
`endif

endmodule

// File: tb/tb_q_ao_unit.sv
// Scoreboard bench for q_ao_unit: directed vectors carry hand-written AO21 results,
// a two-stage reference pipeline queues per-cycle expectations, and a monitor compares them.
module tb_q_ao_unit;
`ifdef Q_AO_EDGE_COUNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clk;
    logic rst;

    q_ao_unit_if #(.CNT_W(CNT_W)) bus ();

    q_ao_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] abc;
        logic       f;
        int         n;
    } vec_t;

    typedef struct {
        logic             w;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam int NV = 31;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: output is presented every cycle, so compare once per edge when an entry is due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("w1", 32'(bus.w1), 32'(e.w));
                check("w3", 32'(bus.w3), 32'(e.w));
                check("w5", 32'(bus.w5), 32'(e.w));
                check("mismatch", 32'(bus.mismatch), 32'd0);
                check("cnt1", 32'(bus.cnt1), 32'(e.cnt));
                check("cnt3", 32'(bus.cnt3), 32'(e.cnt));
                check("cnt5", 32'(bus.cnt5), 32'(e.cnt));
            end
        end
    end

    // Stimulus with a reference pipeline: s1 models the input stage, mw the registered output.
    initial begin
        logic             s1;
        logic             mw;
        logic [CNT_W-1:0] mc;
        exp_t             e;

        vecs = '{
            '{1'b1, 3'b000, 1'b0, 2},
            '{1'b0, 3'b000, 1'b0, 4},
            '{1'b0, 3'b001, 1'b1, 3},
            '{1'b0, 3'b000, 1'b0, 3},
            '{1'b0, 3'b010, 1'b0, 3},
            '{1'b0, 3'b011, 1'b1, 3},
            '{1'b0, 3'b010, 1'b0, 3},
            '{1'b0, 3'b110, 1'b1, 3},
            '{1'b0, 3'b100, 1'b0, 3},
            '{1'b0, 3'b101, 1'b1, 3},
            '{1'b0, 3'b100, 1'b0, 3},
            '{1'b0, 3'b110, 1'b1, 3},
            '{1'b0, 3'b010, 1'b0, 3},
            '{1'b1, 3'b000, 1'b0, 1},
            '{1'b0, 3'b000, 1'b0, 2},
            '{1'b0, 3'b001, 1'b1, 2},
            '{1'b0, 3'b010, 1'b0, 2},
            '{1'b0, 3'b011, 1'b1, 2},
            '{1'b0, 3'b100, 1'b0, 2},
            '{1'b0, 3'b101, 1'b1, 2},
            '{1'b0, 3'b110, 1'b1, 2},
            '{1'b0, 3'b111, 1'b1, 2},
            '{1'b0, 3'b000, 1'b0, 2},
            '{1'b0, 3'b001, 1'b1, 2},
            '{1'b0, 3'b000, 1'b0, 2},
            '{1'b0, 3'b011, 1'b1, 3},
            '{1'b1, 3'b011, 1'b1, 1},
            '{1'b0, 3'b011, 1'b1, 3},
            '{1'b0, 3'b000, 1'b0, 3},
            '{1'b0, 3'b111, 1'b1, 3},
            '{1'b0, 3'b000, 1'b0, 3}
        };

        rst   = 1'b1;
        bus.a = 1'b0;
        bus.b = 1'b0;
        bus.c = 1'b0;
        s1    = 1'b0;
        mw    = 1'b0;
        mc    = '0;

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                @(negedge clk);
                rst = vecs[i].rst;
                {bus.a, bus.b, bus.c} = vecs[i].abc;
                if (vecs[i].rst) begin
                    s1 = 1'b0;
                    mw = 1'b0;
                    mc = '0;
                end else begin
                    if (!mw && s1 && (mc != '1)) mc = mc + 1'b1;
                    mw = s1;
                    s1 = vecs[i].f;
                end
                e.w = mw;
`ifdef Q_AO_EDGE_COUNT_EN
                e.cnt = mc;
`else
                e.cnt = '0;
`endif
                exp_q.push_back(e);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
